// File: rtl/roberto_tx_formatter.sv
// roberto_tx_formatter: snapshots three 3-digit BCD measurements and feeds
// them to the UART transmitter as a 12-character ASCII frame
// "ddd,ddd,ddd#", one character per partida/pronto handshake.
//
// state   | code | meaning
// INICIAL | 0    | idle, waiting for partida
// CARREGA | 1    | snapshot medida1..3, rewind the character index
// ENVIA   | 2    | pulse tx_partida for the current character
// ESPERA  | 3    | wait for tx_pronto, watchdog running
// PROXIMO | 4    | advance to the next character or finish the frame
// FIM     | 5    | pulse pronto, frame complete
// ERRO    | E    | pulse erro, transmitter did not answer in time
module roberto_tx_formatter #(
  parameter logic [6:0]  SEP     = 7'h2C,
  parameter logic [6:0]  TERM    = 7'h23,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        partida,
  input  logic [11:0] medida1,
  input  logic [11:0] medida2,
  input  logic [11:0] medida3,
  input  logic        tx_pronto,
  output logic        tx_partida,
  output logic [6:0]  tx_dado,
  output logic        ocupado,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
  localparam logic [3:0] LAST_IDX = 4'd11;

  typedef enum logic [3:0] {
    INICIAL = 4'h0,
    CARREGA = 4'h1,
    ENVIA   = 4'h2,
    ESPERA  = 4'h3,
    PROXIMO = 4'h4,
    FIM     = 4'h5,
    ERRO    = 4'hE
  } estado_t;

  estado_t         estado, proximo_estado;
  logic [3:0]      indice;
  logic [11:0]     snap1, snap2, snap3;
  logic [WD_W-1:0] watchdog;
  logic [6:0]      char_atual;
  logic            estouro;

  // Digits outside 0..9 are sent as '?' so bad BCD is visible on the link.
  function automatic logic [6:0] bcd_ascii(input logic [3:0] d);
    return (d <= 4'd9) ? (7'h30 + {3'b000, d}) : 7'h3F;
  endfunction

  assign estouro = (TIMEOUT != 0) && (watchdog == WD_LAST);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= proximo_estado;
  end

  // Snapshot, character index and watchdog, advanced according to the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      indice   <= '0;
      snap1    <= '0;
      snap2    <= '0;
      snap3    <= '0;
      watchdog <= '0;
    end else begin
      case (estado)
        CARREGA: begin
          snap1  <= medida1;
          snap2  <= medida2;
          snap3  <= medida3;
          indice <= '0;
        end
        ENVIA:   watchdog <= '0;
        ESPERA:  watchdog <= watchdog + 1'b1;
        PROXIMO: if (indice != LAST_IDX) indice <= indice + 4'd1;
        ERRO:    indice <= '0;
        default: ;
      endcase
    end
  end

  // Character selected by the index: three digit groups, separators, terminator.
  always_comb begin
    char_atual = '0;
    case (indice)
      4'd0:    char_atual = bcd_ascii(snap1[11:8]);
      4'd1:    char_atual = bcd_ascii(snap1[7:4]);
      4'd2:    char_atual = bcd_ascii(snap1[3:0]);
      4'd3:    char_atual = SEP;
      4'd4:    char_atual = bcd_ascii(snap2[11:8]);
      4'd5:    char_atual = bcd_ascii(snap2[7:4]);
      4'd6:    char_atual = bcd_ascii(snap2[3:0]);
      4'd7:    char_atual = SEP;
      4'd8:    char_atual = bcd_ascii(snap3[11:8]);
      4'd9:    char_atual = bcd_ascii(snap3[7:4]);
      4'd10:   char_atual = bcd_ascii(snap3[3:0]);
      4'd11:   char_atual = TERM;
      default: char_atual = '0;
    endcase
  end

  // Next-state logic and Moore outputs decoded from the state register.
  always_comb begin
    proximo_estado = estado;
    tx_partida     = 1'b0;
    tx_dado        = '0;
    ocupado        = 1'b1;
    pronto         = 1'b0;
    erro           = 1'b0;
    db_estado      = estado;
    case (estado)
      INICIAL: begin
        ocupado = 1'b0;
        if (partida) proximo_estado = CARREGA;
      end
      CARREGA: proximo_estado = ENVIA;
      ENVIA: begin
        tx_partida     = 1'b1;
        tx_dado        = char_atual;
        proximo_estado = ESPERA;
      end
      ESPERA: begin
        tx_dado = char_atual;
        if (tx_pronto)    proximo_estado = PROXIMO;
        else if (estouro) proximo_estado = ERRO;
      end
      PROXIMO: proximo_estado = (indice == LAST_IDX) ? FIM : ENVIA;
      FIM: begin
        pronto         = 1'b1;
        proximo_estado = INICIAL;
      end
      ERRO: begin
        erro           = 1'b1;
        proximo_estado = INICIAL;
      end
      default: proximo_estado = INICIAL;
    endcase
  end

endmodule

// File: tb/tb_roberto_tx_formatter.sv
// Bench for roberto_tx_formatter: scoreboard of expected characters, an
// automatic transmitter model answering tx_partida with tx_pronto, and
// directed frames covering timing, snapshot, bad BCD, watchdog and reset.
module tb_roberto_tx_formatter;

  localparam int TO      = 20;
  localparam int ACK_DLY = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        partida = 1'b0;
  logic        tx_pronto = 1'b0;
  logic [11:0] medida1 = '0, medida2 = '0, medida3 = '0;
  logic        tx_partida, ocupado, pronto, erro;
  logic [6:0]  tx_dado;
  logic [3:0]  db_estado;

  int n_tests = 0, n_fail = 0;
  logic [6:0] exp_q[$];
  logic [6:0] held_dado = '0;
  int cyc_n = 0, ack_cyc = 0, part_cyc = 0, frame_chars = 0;
  int n_pronto = 0, n_erro = 0, ack_cnt = 0;
  bit ack_en = 1'b1;
  int p0, e0;

  always #5 clock = ~clock;

  roberto_tx_formatter #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .partida(partida),
    .medida1(medida1), .medida2(medida2), .medida3(medida3),
    .tx_pronto(tx_pronto), .tx_partida(tx_partida), .tx_dado(tx_dado),
    .ocupado(ocupado), .pronto(pronto), .erro(erro), .db_estado(db_estado)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, expv, $time);
    end
  endtask

  function automatic logic [6:0] asc(input logic [3:0] d);
    return (d < 4'd10) ? (7'h30 + 7'(d)) : 7'h3F;
  endfunction

  task automatic push_frame(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    logic [11:0] m[3];
    m[0] = a; m[1] = b; m[2] = c;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(asc(m[i][11:8]));
      exp_q.push_back(asc(m[i][7:4]));
      exp_q.push_back(asc(m[i][3:0]));
      exp_q.push_back((i < 2) ? 7'h2C : 7'h23);
    end
  endtask

  // Transmitter model and output monitor, sampling on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      cyc_n++;
      tx_pronto = 1'b0;
      if (tx_partida) begin
        if (frame_chars > 0) chk("ack_to_partida", cyc_n - ack_cyc, 2);
        frame_chars++;
        part_cyc  = cyc_n;
        held_dado = tx_dado;
        if (exp_q.size() > 0) chk("tx_dado", {25'b0, tx_dado}, {25'b0, exp_q.pop_front()});
        else                  chk("tx_extra", {31'b0, tx_partida}, 0);
        if (ack_en) ack_cnt = ACK_DLY;
      end else if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          tx_pronto = 1'b1;
          ack_cyc   = cyc_n;
        end
      end
      if (db_estado == 4'h3) chk("dado_hold", {25'b0, tx_dado}, {25'b0, held_dado});
      if (pronto) begin
        n_pronto++;
        chk("pronto_lat", cyc_n - ack_cyc, 2);
        chk("pronto_chars", frame_chars, 12);
      end
      if (erro) begin
        n_erro++;
        chk("erro_lat", cyc_n - part_cyc, TO + 1);
      end
    end
  end

  task automatic send_partida();
    @(posedge clock); #1 partida = 1'b1;
    @(posedge clock); #1 partida = 1'b0;
    @(negedge clock);
    chk("ocupado_t1", {31'b0, ocupado}, 1);
    chk("partida_t1", {31'b0, tx_partida}, 0);
    @(negedge clock);
    chk("partida_t2", {31'b0, tx_partida}, 1);
    @(negedge clock);
    chk("partida_t3", {31'b0, tx_partida}, 0);
  endtask

  task automatic wait_done(input int budget);
    int s = n_pronto + n_erro;
    int k = 0;
    while ((n_pronto + n_erro) == s && k < budget) begin
      @(negedge clock); #1;
      k++;
    end
    if ((n_pronto + n_erro) == s) chk("tmo_done", n_pronto + n_erro, s + 1);
  endtask

  task automatic wait_chars(input int n, input int budget);
    int k = 0;
    while (frame_chars < n && k < budget) begin
      @(negedge clock); #1;
      k++;
    end
    if (frame_chars < n) chk("tmo_chars", frame_chars, n);
  endtask

  task automatic run_frame();
    frame_chars = 0;
    send_partida();
    wait_done(400);
    @(negedge clock);
    chk("idle_ocupado", {31'b0, ocupado}, 0);
    chk("queue_left", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_tx_partida", {31'b0, tx_partida}, 0);
    chk("rst_tx_dado", {25'b0, tx_dado}, 0);
    chk("rst_ocupado", {31'b0, ocupado}, 0);
    chk("rst_pronto", {31'b0, pronto}, 0);
    chk("rst_erro", {31'b0, erro}, 0);
    chk("rst_estado", {28'b0, db_estado}, 0);
    reset = 1'b1;

    // Basic frame content and handshake timing.
    medida1 = 12'h123; medida2 = 12'h045; medida3 = 12'h900;
    push_frame(medida1, medida2, medida3);
    run_frame();

    // Measurements change and partida repeats mid-frame: both ignored.
    medida1 = 12'h678; medida2 = 12'h045; medida3 = 12'h321;
    push_frame(medida1, medida2, medida3);
    frame_chars = 0;
    p0 = n_pronto;
    send_partida();
    wait_chars(3, 100);
    medida2 = 12'h777;
    @(posedge clock); #1 partida = 1'b1;
    @(posedge clock); #1 partida = 1'b0;
    wait_done(400);
    repeat (30) @(negedge clock);
    chk("no_second_frame", n_pronto, p0 + 1);
    chk("idle_after_ignore", {31'b0, ocupado}, 0);
    chk("queue_left2", exp_q.size(), 0);

    // Invalid BCD digits become '?'.
    medida1 = 12'hA0F; medida2 = 12'h999; medida3 = 12'hB5C;
    push_frame(medida1, medida2, medida3);
    run_frame();

    // Watchdog abort when the transmitter never answers, then a clean restart.
    ack_en = 1'b0;
    medida1 = 12'h314; medida2 = 12'h159; medida3 = 12'h265;
    exp_q.push_back(asc(medida1[11:8]));
    frame_chars = 0;
    p0 = n_pronto; e0 = n_erro;
    send_partida();
    wait_done(100);
    chk("erro_count", n_erro, e0 + 1);
    chk("wd_no_pronto", n_pronto, p0);
    @(negedge clock);
    chk("wd_estado", {28'b0, db_estado}, 0);
    chk("wd_ocupado", {31'b0, ocupado}, 0);
    ack_en = 1'b1;
    push_frame(medida1, medida2, medida3);
    run_frame();

    // Asynchronous reset during ESPERA of the fifth character.
    medida1 = 12'h246; medida2 = 12'h802; medida3 = 12'h135;
    push_frame(medida1, medida2, medida3);
    frame_chars = 0;
    send_partida();
    wait_chars(5, 200);
    @(negedge clock);
    p0 = n_pronto; e0 = n_erro;
    #2 reset = 1'b0;
    #1;
    chk("arst_tx_partida", {31'b0, tx_partida}, 0);
    chk("arst_tx_dado", {25'b0, tx_dado}, 0);
    chk("arst_ocupado", {31'b0, ocupado}, 0);
    chk("arst_pronto", {31'b0, pronto}, 0);
    chk("arst_erro", {31'b0, erro}, 0);
    chk("arst_estado", {28'b0, db_estado}, 0);
    exp_q.delete();
    repeat (15) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("arst_no_pronto", n_pronto, p0);
    chk("arst_no_erro", n_erro, e0);
    push_frame(medida1, medida2, medida3);
    run_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish by %0t", $time);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/roberto_tx_formatter.md
Name: roberto_tx_formatter

Overview:
- Serial frame formatter that sits directly upstream of the UART transmitter inside the roberto datapath.
- Snapshots the three 12-bit BCD distance measurements (3 digits each) and converts them to a 12-character ASCII frame: "d d d , d d d , d d d #".
- Hands the frame to the transmitter one 7-bit character at a time using a partida/pronto handshake.
- Replaces driving partida_tx directly from the control unit.

Parameters:
- SEP, 7'h2C, ASCII separator sent after medida1 and after medida2.
- TERM, 7'h23, ASCII terminator sent after medida3.
- TIMEOUT, 50000, maximum clock cycles to wait for tx_pronto per character; 0 disables the watchdog.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- partida  input  1  single-cycle request to send one frame.
- medida1  input  12  BCD measurement 1, [11:8] hundreds, [7:4] tens, [3:0] units.
- medida2  input  12  BCD measurement 2, same layout.
- medida3  input  12  BCD measurement 3, same layout.
- tx_pronto  input  1  single-cycle pulse from the UART transmitter when the current character has finished.
- tx_partida  output  1  single-cycle pulse that starts transmission of tx_dado.
- tx_dado  output  7  ASCII character to transmit; held stable from the tx_partida cycle until leaving ESPERA.
- ocupado  output  1  high in every state except INICIAL.
- pronto  output  1  single-cycle pulse after the terminator has been acknowledged.
- erro  output  1  single-cycle pulse on watchdog abort.
- db_estado  output  4  current state code, for the hexa7seg debug display.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=INICIAL, char index=0, snapshot registers=0, watchdog=0.
  - tx_partida=0, tx_dado=0, ocupado=0, pronto=0, erro=0.
- All outputs are Moore, registered from the state and the index.
- States and codes:
  - INICIAL (0): wait for partida. partida=1 -> CARREGA.
  - CARREGA (1): latch medida1..3 into snapshot registers; index=0 -> ENVIA.
  - ENVIA (2): tx_partida=1 for exactly this cycle -> ESPERA; watchdog cleared.
  - ESPERA (3): watchdog increments each cycle.
    - tx_pronto=1 -> PROXIMO.
    - Else if TIMEOUT!=0 and watchdog==TIMEOUT-1 -> ERRO.
    - tx_pronto has priority over timeout in the same cycle.
  - PROXIMO (4): if index==11 -> FIM; else index+1 -> ENVIA.
  - FIM (5): pronto=1 for one cycle -> INICIAL.
  - ERRO (E): erro=1 for one cycle; index=0 -> INICIAL. The frame is not resumed.
- Character map (index -> source):
  - 0,1,2 = medida1 digits, hundreds first; 3 = SEP.
  - 4,5,6 = medida2 digits, hundreds first; 7 = SEP.
  - 8,9,10 = medida3 digits, hundreds first; 11 = TERM.
- Digit encoding:
  - nibble 0..9 -> 7'h30 + nibble.
  - nibble 10..15 -> 7'h3F ('?'), which flags invalid BCD.
- Latency:
  - partida sampled at edge t -> tx_partida high in cycle t+2.
  - After tx_pronto is sampled, the next tx_partida follows 2 cycles later (PROXIMO, then ENVIA).
- Boundary conditions:
  - partida while ocupado=1 is ignored; there is no queueing.
  - medida1..3 changing mid-frame has no effect; only the snapshot is transmitted.
  - tx_pronto in any state other than ESPERA is ignored, including the ENVIA cycle itself.
  - partida and tx_pronto both high in INICIAL: only partida acts.
  - Reset asserted mid-frame: outputs drop immediately; no pronto or erro pulse is emitted.
  - The index never exceeds 11 and never wraps.

Test Plan:
- Frame content: medida1=12'h123, medida2=12'h045, medida3=12'h900, pulse partida, answer each tx_partida with tx_pronto 10 cycles later -> tx_dado sequence 31,32,33,2C,30,34,35,2C,39,30,30,23. Require exactly 12 tx_partida pulses, one pronto pulse 2 cycles after the 12th tx_pronto, then ocupado=0.
- Timing: partida at edge t -> tx_partida=1 in cycle t+2 only, and ocupado=1 from t+1. tx_pronto at edge u -> next tx_partida in cycle u+2.
- Snapshot and ignore: change medida2 to 12'h777 and pulse partida after the 3rd character -> frame is still 045 for medida2, and no second frame starts.
- Invalid BCD: medida1=12'hA0F -> first three characters are 3F,30,3F.
- Watchdog: TIMEOUT=20, never assert tx_pronto -> erro pulse 20 cycles after entering ESPERA, state INICIAL, no pronto. Then a new partida restarts from index 0.
- Async reset: drop reset during ESPERA of character 5 (reset=0 between clock edges) -> all outputs 0 and db_estado=0 without waiting for a clock edge. After release, a new partida yields a complete 12-character frame.
